// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
//
// Frame controller sitting between the UART receiver and the command decoder.
// It assembles frames of the form SOF, ID, LEN, PAYLOAD[LEN], CHK from the
// receiver's byte strobe. CHK is the mod-256 sum of ID, LEN and the payload.
// Accepted frames are held on a valid/ready handshake. Malformed or stalled
// frames produce one-cycle error pulses.
//
// Ports
//   i_Clock        system clock, rising edge
//   i_rst          asynchronous reset, active low
//   i_Rx_DV        one-cycle byte strobe from the UART receiver
//   i_Rx_Byte      received byte, qualified by i_Rx_DV
//   o_Cmd_Valid    accepted frame available (held until transfer)
//   i_Cmd_Ready    downstream accepts the frame
//   o_Cmd_Id       frame ID byte
//   o_Cmd_Len      payload length
//   o_Cmd_Payload  payload, byte k at [8k+7:8k], bytes k >= LEN are zero
//   o_Err_Chk      one-cycle pulse: checksum mismatch
//   o_Err_Len      one-cycle pulse: LEN exceeds MAX_LEN
//   o_Err_Timeout  one-cycle pulse: inter-byte timeout inside a frame
//   o_Drop         one-cycle pulse: byte discarded while a command is held
//   o_Busy         high whenever the controller is not idle
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SOF_BYTE     = 8'hA5,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 8680
) (
    input  logic                   i_Clock,
    input  logic                   i_rst,
    input  logic                   i_Rx_DV,
    input  logic [7:0]             i_Rx_Byte,
    output logic                   o_Cmd_Valid,
    input  logic                   i_Cmd_Ready,
    output logic [7:0]             o_Cmd_Id,
    output logic [7:0]             o_Cmd_Len,
    output logic [8*MAX_LEN-1:0]   o_Cmd_Payload,
    output logic                   o_Err_Chk,
    output logic                   o_Err_Len,
    output logic                   o_Err_Timeout,
    output logic                   o_Drop,
    output logic                   o_Busy
);

    localparam int IDX_W = $clog2(MAX_LEN + 1);
    localparam int TO_W  = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_ID  = 3'd1,
        GET_LEN = 3'd2,
        GET_PAY = 3'd3,
        GET_CHK = 3'd4,
        HOLD    = 3'd5
    } state_t;

    state_t             state;
    logic [7:0]         sum;
    logic [IDX_W-1:0]   pay_idx;
    logic [TO_W-1:0]    idle_cnt;
    logic               in_frame;
    logic               timeout_hit;

    // The inter-byte timer only runs while a frame is partially received.
    assign in_frame = (state == GET_ID) || (state == GET_LEN) ||
                      (state == GET_PAY) || (state == GET_CHK);

    // A byte arriving on the terminal count wins over the timeout.
    assign timeout_hit = in_frame && !i_Rx_DV &&
                         (idle_cnt == TO_W'(TIMEOUT_CLKS - 1));

    // NOTE: all state here is sequential, so every assignment in this block is
    // non-blocking; mixing in blocking writes would make later reads in the
    // same block see the new value and break the one-cycle registered timing.
    always_ff @(posedge i_Clock or negedge i_rst) begin
        if (!i_rst) begin
            state         <= IDLE;
            sum           <= '0;
            pay_idx       <= '0;
            idle_cnt      <= '0;
            o_Cmd_Valid   <= 1'b0;
            o_Cmd_Id      <= '0;
            o_Cmd_Len     <= '0;
            // NOTE: the payload buffer is reset because unused upper bytes must
            // read as zero; that holds from reset as well as after each SOF.
            o_Cmd_Payload <= '0;
            o_Err_Chk     <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Drop        <= 1'b0;
            o_Busy        <= 1'b0;
        end else begin
            // Pulse outputs default low and are raised for one cycle below.
            o_Err_Chk     <= 1'b0;
            o_Err_Len     <= 1'b0;
            o_Err_Timeout <= 1'b0;
            o_Drop        <= 1'b0;

            if (!in_frame || i_Rx_DV) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end

            if (timeout_hit) begin
                o_Err_Timeout <= 1'b1;
                o_Busy        <= 1'b0;
                state         <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_Rx_DV && (i_Rx_Byte == SOF_BYTE)) begin
                            o_Cmd_Payload <= '0;
                            sum           <= '0;
                            o_Busy        <= 1'b1;
                            state         <= GET_ID;
                        end
                    end

                    GET_ID: begin
                        if (i_Rx_DV) begin
                            o_Cmd_Id <= i_Rx_Byte;
                            sum      <= i_Rx_Byte;
                            state    <= GET_LEN;
                        end
                    end

                    GET_LEN: begin
                        if (i_Rx_DV) begin
                            o_Cmd_Len <= i_Rx_Byte;
                            sum       <= sum + i_Rx_Byte;
                            pay_idx   <= '0;
                            if (i_Rx_Byte > 8'(MAX_LEN)) begin
                                o_Err_Len <= 1'b1;
                                o_Busy    <= 1'b0;
                                state     <= IDLE;
                            end else if (i_Rx_Byte == 8'd0) begin
                                state <= GET_CHK;
                            end else begin
                                state <= GET_PAY;
                            end
                        end
                    end

                    GET_PAY: begin
                        if (i_Rx_DV) begin
                            for (int k = 0; k < MAX_LEN; k++) begin
                                if (pay_idx == IDX_W'(k)) begin
                                    o_Cmd_Payload[8*k +: 8] <= i_Rx_Byte;
                                end
                            end
                            sum     <= sum + i_Rx_Byte;
                            pay_idx <= pay_idx + 1'b1;
                            if ((8'(pay_idx) + 8'd1) == o_Cmd_Len) begin
                                state <= GET_CHK;
                            end
                        end
                    end

                    GET_CHK: begin
                        if (i_Rx_DV) begin
                            if (i_Rx_Byte == sum) begin
                                o_Cmd_Valid <= 1'b1;
                                state       <= HOLD;
                            end else begin
                                o_Err_Chk <= 1'b1;
                                o_Busy    <= 1'b0;
                                state     <= IDLE;
                            end
                        end
                    end

                    HOLD: begin
                        // Nothing is buffered behind a held command: any byte
                        // that arrives now, SOF included, is lost.
                        if (i_Rx_DV) begin
                            o_Drop <= 1'b1;
                        end
                        if (o_Cmd_Valid && i_Cmd_Ready) begin
                            o_Cmd_Valid <= 1'b0;
                            o_Busy      <= 1'b0;
                            state       <= IDLE;
                        end
                    end

                    default: begin
                        o_Cmd_Valid <= 1'b0;
                        o_Busy      <= 1'b0;
                        state       <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
